// File: rtl/fft_pkg.sv
// Shared FFT constants, read-FSM state type and the bin-index bit-reversal helper.
// Used by the output reorder buffer and by the butterfly stage modules.
package fft_pkg;

  localparam int FFT_N      = 32;
  localparam int FFT_LOG2N  = 5;
  localparam int FFT_DATA_W = 19;

  typedef enum logic [0:0] {
    RD_IDLE  = 1'b0,
    RD_DRAIN = 1'b1
  } rd_state_e;

  function automatic logic [FFT_LOG2N-1:0] bitrev(input logic [FFT_LOG2N-1:0] idx);
    logic [FFT_LOG2N-1:0] rev;
    rev = {FFT_LOG2N{1'b0}};
    for (int b = 0; b < FFT_LOG2N; b++) begin
      rev[b] = idx[FFT_LOG2N-1-b];
    end
    return rev;
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One frame of complex samples: synchronous write port, asynchronous read port.
// Contents are deliberately not reset; the full flags in the top guard every read.
module fft_reorder_bank
  import fft_pkg::*;
#(
  parameter int N  = FFT_N,
  parameter int AW = FFT_LOG2N,
  parameter int W  = 2 * FFT_DATA_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [N];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fft_output_reorder.sv
// Ping-pong reorder buffer: frames arrive in bit-reversed order and leave in natural
// bin order; one bank fills while the other drains, with no bubble between frames.
module fft_output_reorder
  import fft_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int LOG2N  = FFT_LOG2N
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_in_r,
  input  logic [DATA_W-1:0] data_in_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_out_r,
  output logic [DATA_W-1:0] data_out_i,
  output logic [LOG2N-1:0]  idx_o,
  output logic              sop_o
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] CNT_ZERO = {LOG2N{1'b0}};
  localparam logic [LOG2N-1:0] CNT_ONE  = {{(LOG2N-1){1'b0}}, 1'b1};
  localparam logic [LOG2N-1:0] CNT_LAST = {LOG2N{1'b1}};

  logic [LOG2N-1:0]    wr_cnt_q, wr_cnt_d;
  logic                wr_bank_q, wr_bank_d;
  logic [1:0]          full_q, full_d;
  logic                wr_wrap_s;
  rd_state_e           state_q, state_d;
  logic [LOG2N-1:0]    rd_cnt_q, rd_cnt_d;
  logic                rd_bank_q, rd_bank_d;
  logic                emit_s, emit_bank_s, emit_last_s;
  logic [LOG2N-1:0]    emit_addr_s;
  logic [2*DATA_W-1:0] rdata_s [2];
  logic [2*DATA_W-1:0] rd_word_s;
  logic [1:0]          we_s;
  logic [LOG2N-1:0]    waddr_s;

  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   data_r_q, data_r_d;
  logic [DATA_W-1:0]   data_i_q, data_i_d;
  logic [LOG2N-1:0]    idx_q, idx_d;
  logic                sop_q, sop_d;

  assign waddr_s = bitrev(wr_cnt_q);
  assign we_s[0] = valid_i & ~wr_bank_q;
  assign we_s[1] = valid_i & wr_bank_q;

  fft_reorder_bank #(.N(N), .AW(LOG2N), .W(2*DATA_W)) u_bank0 (
    .clk   (clk),
    .we    (we_s[0]),
    .waddr (waddr_s),
    .wdata ({data_in_r, data_in_i}),
    .raddr (emit_addr_s),
    .rdata (rdata_s[0])
  );

  fft_reorder_bank #(.N(N), .AW(LOG2N), .W(2*DATA_W)) u_bank1 (
    .clk   (clk),
    .we    (we_s[1]),
    .waddr (waddr_s),
    .wdata ({data_in_r, data_in_i}),
    .raddr (emit_addr_s),
    .rdata (rdata_s[1])
  );

  // Write side: count accepted samples, close the bank on wrap.
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    wr_wrap_s = 1'b0;
    if (valid_i) begin
      wr_cnt_d = wr_cnt_q + CNT_ONE;
      if (wr_cnt_q == CNT_LAST) begin
        wr_wrap_s = 1'b1;
        wr_bank_d = ~wr_bank_q;
      end else begin
        wr_wrap_s = 1'b0;
      end
    end else begin
      wr_cnt_d = wr_cnt_q;
    end
  end

  // A bank's last read and a new frame completing never hit the same bank.
  always_comb begin
    full_d = full_q;
    if (emit_last_s) begin
      full_d[emit_bank_s] = 1'b0;
    end else begin
      full_d = full_q;
    end
    if (wr_wrap_s) begin
      full_d[wr_bank_q] = 1'b1;
    end else begin
      full_d[wr_bank_q] = full_d[wr_bank_q];
    end
  end

  // Next-state logic. IDLE emits bin 0 directly so the first bin lands one cycle
  // after the frame completes; the freshly closed bank is the one not being written.
  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    rd_bank_d   = rd_bank_q;
    emit_s      = 1'b0;
    emit_bank_s = rd_bank_q;
    emit_addr_s = rd_cnt_q;
    case (state_q)
      RD_IDLE: begin
        if (full_q != 2'b00) begin
          emit_s      = 1'b1;
          emit_bank_s = full_q[~wr_bank_q] ? ~wr_bank_q : wr_bank_q;
          emit_addr_s = CNT_ZERO;
        end else begin
          emit_s = 1'b0;
        end
      end
      RD_DRAIN: begin
        emit_s      = 1'b1;
        emit_bank_s = rd_bank_q;
        emit_addr_s = rd_cnt_q;
      end
      default: begin
        state_d = RD_IDLE;
      end
    endcase

    emit_last_s = emit_s && (emit_addr_s == CNT_LAST);

    if (emit_s) begin
      if (emit_last_s) begin
        if (full_q[~emit_bank_s]) begin
          state_d   = RD_DRAIN;
          rd_bank_d = ~emit_bank_s;
          rd_cnt_d  = CNT_ZERO;
        end else begin
          state_d  = RD_IDLE;
          rd_cnt_d = CNT_ZERO;
        end
      end else begin
        state_d   = RD_DRAIN;
        rd_bank_d = emit_bank_s;
        rd_cnt_d  = emit_addr_s + CNT_ONE;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Output next values; data and index hold while idle.
  always_comb begin
    rd_word_s = emit_bank_s ? rdata_s[1] : rdata_s[0];
    valid_d   = emit_s;
    sop_d     = 1'b0;
    data_r_d  = data_r_q;
    data_i_d  = data_i_q;
    idx_d     = idx_q;
    if (emit_s) begin
      sop_d    = (emit_addr_s == CNT_ZERO);
      data_r_d = rd_word_s[2*DATA_W-1:DATA_W];
      data_i_d = rd_word_s[DATA_W-1:0];
      idx_d    = emit_addr_s;
    end else begin
      sop_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_cnt_q  <= CNT_ZERO;
      wr_bank_q <= 1'b0;
      full_q    <= 2'b00;
      state_q   <= RD_IDLE;
      rd_cnt_q  <= CNT_ZERO;
      rd_bank_q <= 1'b0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      wr_bank_q <= wr_bank_d;
      full_q    <= full_d;
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
      idx_q    <= CNT_ZERO;
      data_r_q <= {DATA_W{1'b0}};
      data_i_q <= {DATA_W{1'b0}};
    end else begin
      valid_q  <= valid_d;
      sop_q    <= sop_d;
      idx_q    <= idx_d;
      data_r_q <= data_r_d;
      data_i_q <= data_i_d;
    end
  end

  assign valid_o    = valid_q;
  assign sop_o      = sop_q;
  assign idx_o      = idx_q;
  assign data_out_r = data_r_q;
  assign data_out_i = data_i_q;

endmodule

// File: tb/tb_fft_output_reorder.sv
// Scoreboard bench: each completed input frame pushes its 32 natural-order bins, each
// tagged with the cycle it must appear on; a negedge monitor pops and compares.
module tb_fft_output_reorder;

  localparam int N  = 32;
  localparam int DW = 19;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          valid_i = 1'b0;
  logic [DW-1:0] data_in_r = '0;
  logic [DW-1:0] data_in_i = '0;
  logic          valid_o;
  logic [DW-1:0] data_out_r;
  logic [DW-1:0] data_out_i;
  logic [4:0]    idx_o;
  logic          sop_o;

  typedef struct {
    logic [DW-1:0] r;
    logic [DW-1:0] i;
    int            idx;
    int            cyc;
  } exp_t;

  exp_t          q[$];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  bit            mon_en = 1'b0;
  logic [DW-1:0] fr_r[N];
  logic [DW-1:0] fr_i[N];
  int            fcnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  fft_output_reorder dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .data_in_r  (data_in_r),
    .data_in_i  (data_in_i),
    .valid_o    (valid_o),
    .data_out_r (data_out_r),
    .data_out_i (data_out_i),
    .idx_o      (idx_o),
    .sop_o      (sop_o)
  );

  function automatic int brev(input int x);
    int y;
    y = 0;
    for (int b = 0; b < 5; b++) begin
      if (((x >> b) & 1) != 0) y = y | (1 << (4 - b));
    end
    return y;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // One clock of stimulus; a completed frame queues its 32 bins in natural order.
  task automatic drive(input bit v, input logic [DW-1:0] r, input logic [DW-1:0] im);
    exp_t e;
    valid_i   = v;
    data_in_r = r;
    data_in_i = im;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    if (v) begin
      fr_r[fcnt] = r;
      fr_i[fcnt] = im;
      fcnt++;
      if (fcnt == N) begin
        for (int n = 0; n < N; n++) begin
          e.r   = fr_r[brev(n)];
          e.i   = fr_i[brev(n)];
          e.idx = n;
          e.cyc = cyc + 1 + n;
          q.push_back(e);
        end
        fcnt = 0;
      end
    end
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    fcnt = 0;
    check_val("rst_valid", valid_o, 0);
    check_val("rst_sop", sop_o, 0);
    check_val("rst_idx", idx_o, 0);
    check_val("rst_data_r", data_out_r, 0);
    check_val("rst_data_i", data_out_i, 0);
  endtask

  task automatic drain(input string tag);
    for (int t = 0; t < 100 && q.size() > 0; t++) drive(1'b0, '0, '0);
    repeat (3) drive(1'b0, '0, '0);
    check_val(tag, q.size(), 0);
  endtask

  // Monitor: every valid output must match the head of the queue on its exact cycle.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (valid_o) begin
        if (q.size() == 0) begin
          check_val("unexpected_valid", valid_o, 0);
        end else begin
          e = q.pop_front();
          check_val("data_r", data_out_r, e.r);
          check_val("data_i", data_out_i, e.i);
          check_val("idx", idx_o, e.idx);
          check_val("sop", sop_o, (e.idx == 0) ? 1 : 0);
          check_val("out_cycle", cyc, e.cyc);
        end
      end else begin
        if (sop_o) check_val("sop_idle", sop_o, 0);
        if (q.size() > 0 && q[0].cyc <= cyc) begin
          check_val("late_output", cyc, q[0].cyc);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    mon_en = 1'b1;

    // single frame
    for (int k = 0; k < N; k++) drive(1'b1, DW'(k), DW'(100 + k));
    drain("t1_drained");

    // back-to-back frames
    for (int k = 0; k < N; k++) drive(1'b1, DW'(k), DW'(100 + k));
    for (int k = 0; k < N; k++) drive(1'b1, DW'(200 + k), DW'(250 + k));
    drain("t2_drained");

    // input gaps on every other cycle
    for (int k = 0; k < N; k++) begin
      drive(1'b1, DW'(k), DW'(100 + k));
      drive(1'b0, '0, '0);
    end
    drain("t3_drained");

    // partial frame abandoned by reset
    for (int k = 0; k < 20; k++) drive(1'b1, DW'(k), DW'(100 + k));
    do_reset();
    repeat (5) drive(1'b0, '0, '0);
    for (int k = 0; k < N; k++) drive(1'b1, DW'(300 + k), DW'(400 + k));
    drain("t4_drained");

    // reset in the middle of a drain
    for (int k = 0; k < N; k++) drive(1'b1, DW'(500 + k), DW'(550 + k));
    repeat (11) drive(1'b0, '0, '0);
    check_val("t5_idx_before_rst", idx_o, 10);
    check_val("t5_valid_before_rst", valid_o, 1);
    do_reset();
    repeat (40) drive(1'b0, '0, '0);
    for (int k = 0; k < N; k++) drive(1'b1, DW'(600 + k), DW'(650 + k));
    drain("t5_drained");

    // signed extremes at k=1 land on bin 16
    for (int k = 0; k < N; k++) begin
      if (k == 1) drive(1'b1, 19'h40000, 19'h3FFFF);
      else drive(1'b1, DW'(700 + k), DW'(750 + k));
    end
    drain("t6_drained");

    check_val("final_queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
